// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath:
// state codes, opcodes, mux/ALU select encodings and the per-state control word.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_AUIPC    = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [1:0] {M2R_ALUOUT = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2, M2R_IMM = 2'd3} mem_to_reg_e;
  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_RS1 = 2'd1, SRCA_OLDPC = 2'd2} alu_src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2} alu_src_b_e;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_BR = 2'd1, ALU_RFN = 2'd2, ALU_IFN = 2'd3} alu_op_e;

  typedef struct packed {
    logic        pc_en;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    mem_to_reg_e mem_to_reg;
    alu_src_a_e  src_a;
    alu_src_b_e  src_b;
    alu_op_e     alu_op;
    logic        pc_source;
    logic        done;
  } ctrl_t;

  // FETCH carries its ready-qualified fields here; the top gates them with iMemReady.
  // BRANCH pc_en and MEM_WR done are likewise qualified by iZero / iMemReady.
  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_en = 1'b1; c.src_b = SRCB_4; end
      S_DECODE:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_EXEC_R:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.alu_op = ALU_RFN; end
      S_EXEC_I:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.alu_op = ALU_IFN; end
      S_AUIPC:    begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_ALU_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = M2R_ALUOUT; c.done = 1'b1; end
      S_MEM_ADDR: begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; end
      S_MEM_RD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = M2R_MDR; c.done = 1'b1; end
      S_MEM_WR:   begin c.iord = 1'b1; c.mem_write = 1'b1; c.done = 1'b1; end
      S_BRANCH:   begin c.src_a = SRCA_RS1; c.alu_op = ALU_BR; c.pc_source = 1'b1; c.pc_en = 1'b1; c.done = 1'b1; end
      S_JAL:      begin c.reg_write = 1'b1; c.mem_to_reg = M2R_PC; c.pc_en = 1'b1; c.pc_source = 1'b1; c.done = 1'b1; end
      S_JALR:     begin c.reg_write = 1'b1; c.mem_to_reg = M2R_PC; c.src_a = SRCA_RS1; c.src_b = SRCB_IMM;
                        c.pc_en = 1'b1; c.done = 1'b1; end
      S_LUI:      begin c.reg_write = 1'b1; c.mem_to_reg = M2R_IMM; c.done = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface control_multiciclo_if #(parameter int CNT_W = 32);
  logic [6:0]       iOpcode;
  logic             iZero;
  logic             iMemReady;
  logic             oPCEn;
  logic             oIorD;
  logic             oMemRead;
  logic             oMemWrite;
  logic             oIRWrite;
  logic             oRegWrite;
  logic [1:0]       oMemToReg;
  logic [1:0]       oALUSrcA;
  logic [1:0]       oALUSrcB;
  logic [1:0]       oALUOp;
  logic             oPCSource;
  logic             oInstrDone;
  logic             oIllegal;
  logic             oTimeout;
  logic [3:0]       oState;
  logic [CNT_W-1:0] oInstret;
  logic [CNT_W-1:0] oCycle;

  modport master (
    input  iOpcode, iZero, iMemReady,
    output oPCEn, oIorD, oMemRead, oMemWrite, oIRWrite, oRegWrite, oMemToReg,
           oALUSrcA, oALUSrcB, oALUOp, oPCSource, oInstrDone, oIllegal, oTimeout,
           oState, oInstret, oCycle
  );

  modport slave (
    output iOpcode, iZero, iMemReady,
    input  oPCEn, oIorD, oMemRead, oMemWrite, oIRWrite, oRegWrite, oMemToReg,
           oALUSrcA, oALUSrcB, oALUOp, oPCSource, oInstrDone, oIllegal, oTimeout,
           oState, oInstret, oCycle
  );
endinterface

// File: rtl/control_multiciclo_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state; flags expiry on the
// TIMEOUT-th such cycle. TIMEOUT = 0 disables it.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clockCPU,
  input  logic reset,
  input  logic waiting_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic expire_o
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cnt_inc;
  logic         stall;

  assign stall    = waiting_i && !ready_i && (TIMEOUT != 0);
  assign cnt_inc  = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign expire_o = stall && (cnt_inc == (W+1)'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (stall) cnt_d = cnt_inc[W-1:0];
  end

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/control_multiciclo.sv
// Moore FSM sequencing the multicycle RV32I datapath; control word is registered
// from the next state, with only memory-ready / branch-zero qualification done live.
module control_multiciclo
  import control_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic clockCPU,
  input  logic reset,
  control_multiciclo_if.master bus
);
  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] instret_q, cycle_q;
  logic             illegal_q, timeout_q;
  logic             waiting, expire, gate, done;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clockCPU  (clockCPU),
    .reset     (reset),
    .waiting_i (waiting),
    .ready_i   (bus.iMemReady),
    .clear_i   (state_d != state_q),
    .expire_o  (expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.iMemReady) state_d = S_DECODE;
                  else if (expire)   state_d = S_TRAP;
      S_DECODE:
        case (bus.iOpcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      S_EXEC_R, S_EXEC_I, S_AUIPC: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = bus.iOpcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.iMemReady) state_d = S_MEM_WB;
                  else if (expire)   state_d = S_TRAP;
      S_MEM_WR:   if (bus.iMemReady) state_d = S_FETCH;
                  else if (expire)   state_d = S_TRAP;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR, S_LUI: state_d = S_FETCH;
      default:    state_d = S_TRAP;
    endcase
  end

  // Retire happens in the cycle that leaves the last state; MEM_WR only when the write lands.
  assign gate = (state_q != S_FETCH) || bus.iMemReady;
  assign done = ctrl_q.done && ((state_q != S_MEM_WR) || bus.iMemReady);

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH);
      instret_q <= '0;
      cycle_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (done)              instret_q <= instret_q + CNT_W'(1);
      if (state_q != S_TRAP) cycle_q   <= cycle_q + CNT_W'(1);
      if (state_q == S_DECODE && state_d == S_TRAP) illegal_q <= 1'b1;
      if (expire) timeout_q <= 1'b1;
    end
  end

  assign bus.oPCEn      = ctrl_q.pc_en && ((state_q == S_BRANCH) ? bus.iZero : gate);
  assign bus.oIorD      = ctrl_q.iord;
  assign bus.oMemRead   = ctrl_q.mem_read;
  assign bus.oMemWrite  = ctrl_q.mem_write;
  assign bus.oIRWrite   = ctrl_q.ir_write && gate;
  assign bus.oRegWrite  = ctrl_q.reg_write;
  assign bus.oMemToReg  = ctrl_q.mem_to_reg;
  assign bus.oALUSrcA   = ctrl_q.src_a;
  assign bus.oALUSrcB   = gate ? ctrl_q.src_b : SRCB_RS2;
  assign bus.oALUOp     = ctrl_q.alu_op;
  assign bus.oPCSource  = ctrl_q.pc_source;
  assign bus.oInstrDone = done;
  assign bus.oIllegal   = illegal_q;
  assign bus.oTimeout   = timeout_q;
  assign bus.oState     = state_q;
  assign bus.oInstret   = instret_q;
  assign bus.oCycle     = cycle_q;
endmodule

// File: tb/tb_control_multiciclo.sv
// Directed-vector bench: each cycle's expected control word goes into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_control_multiciclo;
  import control_pkg::*;

  logic clockCPU = 1'b0;
  logic reset;
  always #5 clockCPU = ~clockCPU;

  control_multiciclo_if #(.CNT_W(32)) bus ();

  control_multiciclo #(.CNT_W(32), .TIMEOUT(4)) dut (
    .clockCPU (clockCPU),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] ret;
    logic [31:0] cyc;
    logic        ill;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cyc, exp_ret;
  logic exp_ill, exp_to;

  logic [15:0] F_RDY, F_WAIT, DEC, EXR, EXI, AUI, AWB, MA, MRD, MWB, MWR_W, MWR_R;
  logic [15:0] BR_T, BR_N, JALC, JALRC, LUIC, TRAPC;

  wire [15:0] act_ctl = {bus.oPCEn, bus.oIorD, bus.oMemRead, bus.oMemWrite, bus.oIRWrite,
                         bus.oRegWrite, bus.oMemToReg, bus.oALUSrcA, bus.oALUSrcB,
                         bus.oALUOp, bus.oPCSource, bus.oInstrDone};

  // {pcen,iord,mrd,mwr,irw,rw,m2r,srcA,srcB,aluop,pcsrc,done}
  function automatic logic [15:0] mk(input bit pcen, iord, mrd, mwr, irw, rw,
                                     input bit [1:0] m2r, sa, sb, op,
                                     input bit pcs, dn);
    return {pcen, iord, mrd, mwr, irw, rw, m2r, sa, sb, op, pcs, dn};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clockCPU) begin
    exp_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk({r.name, " state"},   32'(bus.oState),   32'(r.st));
      chk({r.name, " ctrl"},    32'(act_ctl),      32'(r.ctl));
      chk({r.name, " instret"}, bus.oInstret,      r.ret);
      chk({r.name, " cycle"},   bus.oCycle,        r.cyc);
      chk({r.name, " illegal"}, 32'(bus.oIllegal), 32'(r.ill));
      chk({r.name, " timeout"}, 32'(bus.oTimeout), 32'(r.to));
    end
  end

  task automatic push(input string n, input state_e st, input logic [15:0] c);
    exp_t r;
    r.name = n; r.st = st; r.ctl = c; r.ret = exp_ret; r.cyc = exp_cyc;
    r.ill = exp_ill; r.to = exp_to;
    q.push_back(r);
  endtask

  task automatic step(input string n, input logic rdy, input logic zr,
                      input logic [6:0] op, input state_e st, input logic [15:0] c);
    bus.iMemReady = rdy; bus.iZero = zr; bus.iOpcode = op;
    push(n, st, c);
    if (st != S_TRAP) exp_cyc++;
    if (c[0]) exp_ret++;
    @(posedge clockCPU); #1;
  endtask

  task automatic rst_cycle(input string n);
    reset = 1'b1; bus.iMemReady = 1'b0;
    exp_cyc = 0; exp_ret = 0; exp_ill = 1'b0; exp_to = 1'b0;
    push(n, S_FETCH, F_WAIT);
    @(posedge clockCPU); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus.iOpcode = '0; bus.iZero = 1'b0; bus.iMemReady = 1'b0;
    exp_cyc = 0; exp_ret = 0; exp_ill = 1'b0; exp_to = 1'b0;
    F_RDY  = mk(1,0,1,0,1,0, 0,0,1,0, 0,0);
    F_WAIT = mk(0,0,1,0,0,0, 0,0,0,0, 0,0);
    DEC    = mk(0,0,0,0,0,0, 0,2,2,0, 0,0);
    EXR    = mk(0,0,0,0,0,0, 0,1,0,2, 0,0);
    EXI    = mk(0,0,0,0,0,0, 0,1,2,3, 0,0);
    AUI    = mk(0,0,0,0,0,0, 0,2,2,0, 0,0);
    AWB    = mk(0,0,0,0,0,1, 0,0,0,0, 0,1);
    MA     = mk(0,0,0,0,0,0, 0,1,2,0, 0,0);
    MRD    = mk(0,1,1,0,0,0, 0,0,0,0, 0,0);
    MWB    = mk(0,0,0,0,0,1, 1,0,0,0, 0,1);
    MWR_W  = mk(0,1,0,1,0,0, 0,0,0,0, 0,0);
    MWR_R  = mk(0,1,0,1,0,0, 0,0,0,0, 0,1);
    BR_T   = mk(1,0,0,0,0,0, 0,1,0,1, 1,1);
    BR_N   = mk(0,0,0,0,0,0, 0,1,0,1, 1,1);
    JALC   = mk(1,0,0,0,0,1, 2,0,0,0, 1,1);
    JALRC  = mk(1,0,0,0,0,1, 2,1,2,0, 0,1);
    LUIC   = mk(0,0,0,0,0,1, 3,0,0,0, 0,1);
    TRAPC  = '0;
    @(posedge clockCPU); #1;
    rst_cycle("reset");

    // add x3,x1,x2
    step("add F",  1, 0, OP_R, S_FETCH,  F_RDY);
    step("add D",  1, 0, OP_R, S_DECODE, DEC);
    step("add EX", 1, 0, OP_R, S_EXEC_R, EXR);
    step("add WB", 1, 0, OP_R, S_ALU_WB, AWB);

    // lw with three wait cycles in MEM_RD, retires on cycle 8
    step("lw F",  1, 0, OP_LOAD, S_FETCH,    F_RDY);
    step("lw D",  1, 0, OP_LOAD, S_DECODE,   DEC);
    step("lw MA", 1, 0, OP_LOAD, S_MEM_ADDR, MA);
    for (int i = 0; i < 3; i++) step("lw wait", 0, 0, OP_LOAD, S_MEM_RD, MRD);
    step("lw RD", 1, 0, OP_LOAD, S_MEM_RD, MRD);
    step("lw WB", 1, 0, OP_LOAD, S_MEM_WB, MWB);

    // beq taken then not taken
    step("beqT F",  1, 1, OP_BR, S_FETCH,  F_RDY);
    step("beqT D",  1, 1, OP_BR, S_DECODE, DEC);
    step("beqT BR", 1, 1, OP_BR, S_BRANCH, BR_T);
    step("beqN F",  1, 0, OP_BR, S_FETCH,  F_RDY);
    step("beqN D",  1, 0, OP_BR, S_DECODE, DEC);
    step("beqN BR", 1, 0, OP_BR, S_BRANCH, BR_N);

    // sw, addi, auipc, jal, jalr, lui with ready tied high
    step("sw F",  1, 0, OP_STORE, S_FETCH,    F_RDY);
    step("sw D",  1, 0, OP_STORE, S_DECODE,   DEC);
    step("sw MA", 1, 0, OP_STORE, S_MEM_ADDR, MA);
    step("sw WR", 1, 0, OP_STORE, S_MEM_WR,   MWR_R);
    step("addi F",  1, 0, OP_I, S_FETCH,  F_RDY);
    step("addi D",  1, 0, OP_I, S_DECODE, DEC);
    step("addi EX", 1, 0, OP_I, S_EXEC_I, EXI);
    step("addi WB", 1, 0, OP_I, S_ALU_WB, AWB);
    step("auipc F",  1, 0, OP_AUIPC, S_FETCH,  F_RDY);
    step("auipc D",  1, 0, OP_AUIPC, S_DECODE, DEC);
    step("auipc EX", 1, 0, OP_AUIPC, S_AUIPC,  AUI);
    step("auipc WB", 1, 0, OP_AUIPC, S_ALU_WB, AWB);
    step("jal F", 1, 0, OP_JAL, S_FETCH,  F_RDY);
    step("jal D", 1, 0, OP_JAL, S_DECODE, DEC);
    step("jal X", 1, 0, OP_JAL, S_JAL,    JALC);
    step("jalr F", 1, 0, OP_JALR, S_FETCH,  F_RDY);
    step("jalr D", 1, 0, OP_JALR, S_DECODE, DEC);
    step("jalr X", 1, 0, OP_JALR, S_JALR,   JALRC);
    step("lui F", 1, 0, OP_LUI, S_FETCH,  F_RDY);
    step("lui D", 1, 0, OP_LUI, S_DECODE, DEC);
    step("lui X", 1, 0, OP_LUI, S_LUI,    LUIC);

    // ready arrives on the 4th fetch wait cycle: no timeout
    for (int i = 0; i < 3; i++) step("late F wait", 0, 0, OP_LUI, S_FETCH, F_WAIT);
    step("late F", 1, 0, OP_LUI, S_FETCH,  F_RDY);
    step("late D", 1, 0, OP_LUI, S_DECODE, DEC);
    step("late X", 1, 0, OP_LUI, S_LUI,    LUIC);

    // reset during a stalled store aborts it
    step("swab F",  1, 0, OP_STORE, S_FETCH,    F_RDY);
    step("swab D",  1, 0, OP_STORE, S_DECODE,   DEC);
    step("swab MA", 1, 0, OP_STORE, S_MEM_ADDR, MA);
    step("swab WR", 0, 0, OP_STORE, S_MEM_WR,   MWR_W);
    rst_cycle("swab rst");

    // illegal opcode traps and freezes oCycle
    step("ill F", 1, 0, 7'b0000000, S_FETCH,  F_RDY);
    step("ill D", 1, 0, 7'b0000000, S_DECODE, DEC);
    exp_ill = 1'b1;
    for (int i = 0; i < 3; i++) step("ill trap", 1, 0, 7'b0000000, S_TRAP, TRAPC);
    rst_cycle("ill rst");

    // memory never ready in FETCH: times out on the 4th wait
    for (int i = 0; i < 4; i++) step("to F wait", 0, 0, OP_R, S_FETCH, F_WAIT);
    exp_to = 1'b1;
    for (int i = 0; i < 2; i++) step("to trap", 0, 0, OP_R, S_TRAP, TRAPC);
    rst_cycle("to rst");

    step("add2 F",  1, 0, OP_R, S_FETCH,  F_RDY);
    step("add2 D",  1, 0, OP_R, S_DECODE, DEC);
    step("add2 EX", 1, 0, OP_R, S_EXEC_R, EXR);
    step("add2 WB", 1, 0, OP_R, S_ALU_WB, AWB);

    repeat (2) @(posedge clockCPU);
    chk("queue drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
